// File: rtl/uart_tx_engine.sv
// uart_tx_engine: FIFO-buffered UART serialiser with 5-8 data bits, optional parity,
// 1/2 stop bits, oversampled bit timing and line-break generation.
module uart_tx_engine #(
  parameter int OVS   = 16,
  parameter int PTR_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             baud_tick_i,
  input  logic             tx_data_vld_i,
  input  logic [7:0]       tx_data_i,
  input  logic [1:0]       data_len_i,
  input  logic             parity_en_i,
  input  logic             even_parity_i,
  input  logic             stop2_i,
  input  logic             break_i,
  output logic             tx_o,
  output logic             tx_busy_o,
  output logic             tx_empty_o,
  output logic             tx_buffer_full_o,
  output logic             tx_overrun_o,
  output logic [PTR_W:0]   tx_level_o
);
  localparam int CW = $clog2(OVS);
  localparam int DEPTH = 2**PTR_W;
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
                         S_PARITY = 3'd3, S_STOP = 3'd4, S_BREAK = 3'd5;
  logic [7:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0] level_q, level_d;
  logic [2:0] state_q, state_d, bit_q, bit_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [7:0] shift_q, shift_d, mask;
  logic [1:0] len_q, len_d;
  logic pen_q, pen_d, stop2_q, stop2_d, stop_q, stop_d, par_q, par_d, tx_q, tx_d;
  logic busy_q, empty_q, full_q, ovr_q;
  logic empty, full, pop, push, last;
  assign empty = level_q == '0;
  assign full = level_q == (PTR_W+1)'(DEPTH);
  assign last = baud_tick_i && tick_q == CW'(OVS-1);
  assign push = tx_data_vld_i && (!full || pop);
  assign level_d = level_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  assign mask = 8'hff >> (2'd3 - data_len_i);
  always_comb begin
    state_d = state_q;
    tick_d = tick_q;
    bit_d = bit_q;
    shift_d = shift_q;
    len_d = len_q;
    pen_d = pen_q;
    stop2_d = stop2_q;
    stop_d = stop_q;
    par_d = par_q;
    tx_d = tx_q;
    pop = 1'b0;
    if (state_q != S_IDLE && baud_tick_i) tick_d = last ? '0 : tick_q + 1'b1;
    case (state_q)
      // break wins over a queued byte; frame config is captured only here
      S_IDLE: if (baud_tick_i && break_i) begin
        state_d = S_BREAK;
        tx_d = 1'b0;
      end else if (baud_tick_i && !empty) begin
        pop = 1'b1;
        shift_d = mem_q[rd_ptr_q];
        len_d = data_len_i;
        pen_d = parity_en_i;
        stop2_d = stop2_i;
        par_d = ^(mem_q[rd_ptr_q] & mask) ^ ~even_parity_i;
        tx_d = 1'b0;
        state_d = S_START;
      end
      S_START: if (last) begin
        tx_d = shift_q[0];
        shift_d = shift_q >> 1;
        bit_d = '0;
        state_d = S_DATA;
      end
      S_DATA: if (last) begin
        if (bit_q == {1'b0, len_q} + 3'd4) begin
          state_d = pen_q ? S_PARITY : S_STOP;
          tx_d = pen_q ? par_q : 1'b1;
          stop_d = 1'b0;
        end else begin
          tx_d = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d = bit_q + 1'b1;
        end
      end
      S_PARITY: if (last) begin
        tx_d = 1'b1;
        stop_d = 1'b0;
        state_d = S_STOP;
      end
      S_STOP: if (last) begin
        stop_d = 1'b1;
        state_d = (stop2_q && !stop_q) ? S_STOP : S_IDLE;
      end
      // line held low while requested, then one mark bit before returning to IDLE
      S_BREAK: begin
        tx_d = !break_i;
        if (break_i) tick_d = '0;
        else if (last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) if (push) mem_q[wr_ptr_q] <= tx_data_i;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      tick_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      len_q <= '0;
      pen_q <= 1'b0;
      stop2_q <= 1'b0;
      stop_q <= 1'b0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      busy_q <= 1'b0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      len_q <= len_d;
      pen_q <= pen_d;
      stop2_q <= stop2_d;
      stop_q <= stop_d;
      par_q <= par_d;
      tx_q <= tx_d;
      wr_ptr_q <= wr_ptr_q + PTR_W'(push);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      level_q <= level_d;
      busy_q <= state_d != S_IDLE;
      empty_q <= level_d == '0 && state_d == S_IDLE;
      full_q <= level_d == (PTR_W+1)'(DEPTH);
      ovr_q <= tx_data_vld_i && full && !pop;
    end
  end
  assign tx_o = tx_q;
  assign tx_busy_o = busy_q;
  assign tx_empty_o = empty_q;
  assign tx_buffer_full_o = full_q;
  assign tx_overrun_o = ovr_q;
  assign tx_level_o = level_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed scoreboard bench; expected frames are queued at write
// time and a line monitor checks every bit at its first and last oversample tick.
module tb_uart_tx_engine;
  localparam int OVS = 16;
  logic clk_i = 1'b0, rst_n_i = 1'b0, baud_tick_i = 1'b0, tx_data_vld_i = 1'b0;
  logic parity_en_i = 1'b0, even_parity_i = 1'b0, stop2_i = 1'b0, break_i = 1'b0;
  logic [7:0] tx_data_i = 8'h00;
  logic [1:0] data_len_i = 2'd3;
  logic tx_o, tx_busy_o, tx_empty_o, tx_buffer_full_o, tx_overrun_o;
  logic [3:0] tx_level_o;
  typedef struct { logic [11:0] bits; int n; } frame_t;
  frame_t exp_q[$];
  int starts[$];
  int checks = 0, failures = 0, tick_n = 0, frames_done = 0, tick_ph = 0;
  int tw, t, r;
  bit tick_en = 1'b0, mon_en = 1'b1, mon_prev;
  frame_t mon_f;
  int mon_t0;

  uart_tx_engine #(.OVS(OVS), .PTR_W(3)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .baud_tick_i(baud_tick_i),
    .tx_data_vld_i(tx_data_vld_i), .tx_data_i(tx_data_i), .data_len_i(data_len_i),
    .parity_en_i(parity_en_i), .even_parity_i(even_parity_i), .stop2_i(stop2_i),
    .break_i(break_i), .tx_o(tx_o), .tx_busy_o(tx_busy_o), .tx_empty_o(tx_empty_o),
    .tx_buffer_full_o(tx_buffer_full_o), .tx_overrun_o(tx_overrun_o), .tx_level_o(tx_level_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) if (baud_tick_i) tick_n <= tick_n + 1;
  initial forever begin
    @(negedge clk_i);
    if (tick_en) begin
      tick_ph = (tick_ph + 1) % 4;
      baud_tick_i = (tick_ph == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] d);
    frame_t f;
    int nd, k;
    logic p;
    nd = 5 + int'(data_len_i);
    f.bits = '0;
    p = 1'b0;
    for (int i = 0; i < nd; i++) begin
      f.bits[1+i] = d[i];
      p = p ^ d[i];
    end
    k = 1 + nd;
    if (parity_en_i) begin
      f.bits[k] = even_parity_i ? p : ~p;
      k++;
    end
    f.bits[k] = 1'b1;
    k++;
    if (stop2_i) begin
      f.bits[k] = 1'b1;
      k++;
    end
    f.n = k;
    return f;
  endfunction

  task automatic wr(input logic [7:0] d, input bit accepted);
    tx_data_vld_i = 1'b1;
    tx_data_i = d;
    if (accepted) exp_q.push_back(mk(d));
    @(negedge clk_i);
    tx_data_vld_i = 1'b0;
  endtask

  task automatic wait_tick(input int target, input bit abortable);
    int c = 0;
    while (tick_n < target && !(abortable && !mon_en) && c < 3000) begin
      @(negedge clk_i);
      c++;
    end
    if (c >= 3000) chk("tick_wait", tick_n, target);
  endtask

  task automatic wait_frames(input int n);
    int c = 0;
    while (frames_done < n && c < 30000) begin
      @(negedge clk_i);
      c++;
    end
    chk("frames_done", frames_done, n);
  endtask

  task automatic wait_starts(input int n);
    int c = 0;
    while (starts.size() < n && c < 30000) begin
      @(negedge clk_i);
      c++;
    end
    chk("frame_starts", starts.size(), n);
  endtask

  // line monitor: a falling edge outside a break request is a start bit
  initial begin
    mon_prev = 1'b1;
    forever begin
      @(negedge clk_i);
      if (mon_en && mon_prev && !tx_o && !break_i) begin
        mon_t0 = tick_n;
        starts.push_back(mon_t0);
        chk("busy_start", tx_busy_o, 1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL unexpected_frame observed=start_bit expected=idle_line");
        end else begin
          mon_f = exp_q.pop_front();
          for (int b = 0; b < mon_f.n; b++) begin
            wait_tick(mon_t0 + OVS*b, 1'b1);
            if (mon_en) chk($sformatf("bit%0d_head", b), tx_o, mon_f.bits[b]);
            wait_tick(mon_t0 + OVS*b + OVS - 1, 1'b1);
            if (mon_en) chk($sformatf("bit%0d_tail", b), tx_o, mon_f.bits[b]);
            if (mon_en && b == mon_f.n - 1) chk("busy_last_tick", tx_busy_o, 1);
          end
          wait_tick(mon_t0 + OVS*mon_f.n, 1'b1);
          if (mon_en) begin
            chk("busy_frame_end", tx_busy_o, 0);
            chk("line_frame_end", tx_o, 1);
            frames_done++;
          end
        end
      end
      mon_prev = tx_o;
    end
  end

  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_tx", tx_o, 1);
    chk("rst_busy", tx_busy_o, 0);
    chk("rst_empty", tx_empty_o, 1);
    chk("rst_full", tx_buffer_full_o, 0);
    chk("rst_overrun", tx_overrun_o, 0);
    chk("rst_level", tx_level_o, 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    tick_en = 1'b1;
    // 8N1 0xA5
    wr(8'hA5, 1'b1);
    tw = tick_n;
    chk("level_after_write", tx_level_o, 1);
    chk("empty_after_write", tx_empty_o, 0);
    chk("full_after_write", tx_buffer_full_o, 0);
    wait_frames(1);
    chk("start_latency", starts[0], tw + 1);
    chk("empty_after_frame", tx_empty_o, 1);
    chk("level_after_frame", tx_level_o, 0);
    // 7E2 0x35, config scrambled once the frame has started
    data_len_i = 2'd2; parity_en_i = 1'b1; even_parity_i = 1'b1; stop2_i = 1'b1;
    wr(8'h35, 1'b1);
    wait_starts(2);
    data_len_i = 2'd0; parity_en_i = 1'b0; even_parity_i = 1'b0; stop2_i = 1'b0;
    wait_frames(2);
    // 5O1 and 5E1 with 0x1F
    data_len_i = 2'd0; parity_en_i = 1'b1; even_parity_i = 1'b0; stop2_i = 1'b0;
    wr(8'h1F, 1'b1);
    wait_frames(3);
    even_parity_i = 1'b1;
    wr(8'h1F, 1'b1);
    wait_frames(4);
    // overrun with the baud tick stopped
    data_len_i = 2'd3; parity_en_i = 1'b0; even_parity_i = 1'b0; stop2_i = 1'b0;
    tick_en = 1'b0;
    @(negedge clk_i);
    baud_tick_i = 1'b0;
    @(negedge clk_i);
    starts.delete();
    for (int i = 0; i < 9; i++) begin
      wr(8'hC0 + 8'(i), i < 8);
      chk($sformatf("ovr_level_%0d", i), tx_level_o, (i < 8) ? i + 1 : 8);
      chk($sformatf("ovr_pulse_%0d", i), tx_overrun_o, i == 8);
    end
    chk("full_flag", tx_buffer_full_o, 1);
    @(negedge clk_i);
    chk("ovr_pulse_clears", tx_overrun_o, 0);
    chk("level_held_full", tx_level_o, 8);
    // write on the same edge as the first pop while full
    baud_tick_i = 1'b1;
    wr(8'h99, 1'b1);
    baud_tick_i = 1'b0;
    chk("pop_write_no_ovr", tx_overrun_o, 0);
    chk("pop_write_level", tx_level_o, 8);
    chk("pop_write_full", tx_buffer_full_o, 1);
    tick_en = 1'b1;
    wait_frames(13);
    // frame length plus the single IDLE tick before the next start
    chk("b2b_gap_01", starts[1] - starts[0], OVS*10 + 1);
    chk("b2b_gap_12", starts[2] - starts[1], OVS*10 + 1);
    // break raised mid-frame
    wr(8'h5A, 1'b1);
    wr(8'hE7, 1'b1);
    wait_starts(10);
    wait_tick(tick_n + 40, 1'b0);
    break_i = 1'b1;
    wait_frames(14);
    t = tick_n;
    wait_tick(t + 20, 1'b0);
    chk("break_line_low", tx_o, 0);
    chk("break_busy", tx_busy_o, 1);
    chk("break_level", tx_level_o, 1);
    r = tick_n;
    break_i = 1'b0;
    wait_tick(r + 8, 1'b0);
    chk("mark_line_high", tx_o, 1);
    chk("mark_busy", tx_busy_o, 1);
    wait_tick(r + OVS, 1'b0);
    chk("mark_done_busy", tx_busy_o, 0);
    chk("mark_done_line", tx_o, 1);
    chk("mark_done_level", tx_level_o, 1);
    wait_frames(15);
    chk("break_restart_tick", starts[starts.size()-1], r + OVS + 1);
    // asynchronous reset mid-frame
    wr(8'h3C, 1'b1);
    wr(8'hC3, 1'b1);
    wait_starts(12);
    wait_tick(tick_n + 50, 1'b0);
    mon_en = 1'b0;
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_tx", tx_o, 1);
    chk("mid_rst_level", tx_level_o, 0);
    chk("mid_rst_busy", tx_busy_o, 0);
    chk("mid_rst_empty", tx_empty_o, 1);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    exp_q.delete();
    wait_tick(tick_n + 40, 1'b0);
    chk("post_rst_tx", tx_o, 1);
    chk("post_rst_level", tx_level_o, 0);
    chk("post_rst_busy", tx_busy_o, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
